// File: rtl/pipelined_cla_addsub_if.sv
// pipelined_cla_addsub_if: operand/result stream bundle for the pipelined add/sub unit
interface pipelined_cla_addsub_if #(parameter int DATA_WIDTH = 16);
  logic                  i_valid;
  logic                  o_ready;
  logic [DATA_WIDTH-1:0] iv_a;
  logic [DATA_WIDTH-1:0] iv_b;
  logic                  i_cin;
  logic                  i_sub;
  logic                  o_valid;
  logic                  i_ready;
  logic [DATA_WIDTH-1:0] ov_sum;
  logic                  o_cout;
  logic                  o_ovf;
  modport slave (
    input  i_valid, iv_a, iv_b, i_cin, i_sub, i_ready,
    output o_ready, o_valid, ov_sum, o_cout, o_ovf
  );
  modport master (
    output i_valid, iv_a, iv_b, i_cin, i_sub, i_ready,
    input  o_ready, o_valid, ov_sum, o_cout, o_ovf
  );
endinterface

// File: rtl/pipelined_cla_addsub.sv
// pipelined_cla_addsub: carry-lookahead add/sub, one carry segment per pipeline stage
module pipelined_cla_addsub #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_STAGES = 4
) (
  input logic                 i_clk,
  input logic                 i_rst_n,
  pipelined_cla_addsub_if.slave bus
);
  localparam int N  = NUM_STAGES;
  localparam int SW = DATA_WIDTH / NUM_STAGES;

  // returns {carry into segment MSB, carry out, sum} using flattened lookahead terms
  function automatic logic [SW+1:0] cla(input logic [SW-1:0] a, input logic [SW-1:0] b, input logic ci);
    logic [SW-1:0] g, p;
    logic [SW:0]   c;
    logic          pp, acc;
    g = a & b;
    p = a ^ b;
    c = '0;
    c[0] = ci;
    for (int i = 0; i < SW; i++) begin
      pp  = 1'b1;
      acc = 1'b0;
      for (int j = i; j >= 0; j--) begin
        acc = acc | (pp & g[j]);
        pp  = pp & p[j];
      end
      c[i+1] = acc | (pp & ci);
    end
    return {c[SW-1], c[SW], p ^ c[SW-1:0]};
  endfunction

  logic [DATA_WIDTH-1:0] a_q [N];
  logic [DATA_WIDTH-1:0] b_q [N];
  logic [DATA_WIDTH-1:0] s_q [N];
  logic [DATA_WIDTH-1:0] a_x [N];
  logic [DATA_WIDTH-1:0] b_x [N];
  logic [DATA_WIDTH-1:0] s_x [N];
  logic [DATA_WIDTH-1:0] s_d [N];
  logic [N-1:0]          v_q, c_q, v_x, c_x, c_d, adv;
  logic                  ovf_q, ovf_d;
  logic [SW+1:0]         r;

  // stage inputs, per-segment CLA and the backpressure chain (free of self-loops)
  always_comb begin
    a_x[0] = bus.iv_a;
    b_x[0] = bus.i_sub ? ~bus.iv_b : bus.iv_b;
    c_x[0] = bus.i_sub ^ bus.i_cin;
    s_x[0] = '0;
    v_x[0] = bus.i_valid;
    for (int k = 1; k < N; k++) begin
      a_x[k] = a_q[k-1];
      b_x[k] = b_q[k-1];
      c_x[k] = c_q[k-1];
      s_x[k] = s_q[k-1];
      v_x[k] = v_q[k-1];
    end
    r = '0;
    for (int k = 0; k < N; k++) begin
      r                   = cla(a_x[k][k*SW +: SW], b_x[k][k*SW +: SW], c_x[k]);
      s_d[k]              = s_x[k];
      s_d[k][k*SW +: SW]  = r[SW-1:0];
      c_d[k]              = r[SW];
      adv[k]              = bus.i_ready | (|((~v_q) >> k));
    end
    ovf_d = r[SW+1] ^ r[SW];
  end

  // advance each stage when it or something downstream can move; data only on valid beats
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      v_q   <= '0;
      c_q   <= '0;
      ovf_q <= 1'b0;
      for (int k = 0; k < N; k++) begin
        a_q[k] <= '0;
        b_q[k] <= '0;
        s_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < N; k++) begin
        if (adv[k]) begin
          v_q[k] <= v_x[k];
          if (v_x[k]) begin
            a_q[k] <= a_x[k];
            b_q[k] <= b_x[k];
            s_q[k] <= s_d[k];
            c_q[k] <= c_d[k];
          end
        end
      end
      if (adv[N-1] && v_x[N-1]) ovf_q <= ovf_d;
    end
  end

  assign bus.o_ready = adv[0];
  assign bus.o_valid = v_q[N-1];
  assign bus.ov_sum  = s_q[N-1];
  assign bus.o_cout  = c_q[N-1];
  assign bus.o_ovf   = ovf_q;
endmodule

// File: tb/tb_pipelined_cla_addsub.sv
// tb_pipelined_cla_addsub: random and directed checks against an arithmetic reference model
module tb_pipelined_cla_addsub;
  localparam int W = 16;
  localparam int N = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pipelined_cla_addsub_if #(.DATA_WIDTH(W)) bus ();
  pipelined_cla_addsub #(.DATA_WIDTH(W), .NUM_STAGES(N)) dut (.i_clk(clk), .i_rst_n(rst_n), .bus(bus));

  typedef struct { logic [W-1:0] s; logic c; logic o; int t; } exp_t;

  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  bit   exact = 1'b0;
  bit   done = 1'b0;
  exp_t q[$];

  always @(posedge clk) cyc <= cyc + 1;

  // {ovf, cout, sum} from plain integer arithmetic
  function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci, input logic sub);
    int ua, ub, sa, sb, c, u, s;
    logic [W-1:0] lo;
    ua = int'(a);
    ub = int'(b);
    sa = int'($signed(a));
    sb = int'($signed(b));
    c  = ci ? 1 : 0;
    u  = sub ? ua - ub - c : ua + ub + c;
    s  = sub ? sa - sb - c : sa + sb + c;
    lo = u[W-1:0];
    return {(s < -(2**(W-1))) || (s >= 2**(W-1)), sub ? (u >= 0) : (u >= 2**W), lo};
  endfunction

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask

  // scoreboard: order, values, latency, ready rule and stall stability
  logic [W-1:0] ps;
  logic         pc, po, pv;
  bit           pstall = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    logic [W+1:0] m;
    if (!rst_n) begin
      q.delete();
      pstall = 1'b0;
    end else begin
      if (pstall) begin
        chk("hold_valid", 32'(bus.o_valid), 32'(pv));
        chk("hold_sum", 32'(bus.ov_sum), 32'(ps));
        chk("hold_cout", 32'(bus.o_cout), 32'(pc));
        chk("hold_ovf", 32'(bus.o_ovf), 32'(po));
      end
      chk("o_ready", 32'(bus.o_ready), 32'(!(q.size() == N && !bus.i_ready)));
      if (bus.o_valid) begin
        if (q.size() == 0) chk("spurious_valid", 32'(1), 32'(0));
        else if (bus.i_ready) begin
          e = q.pop_front();
          chk("sum", 32'(bus.ov_sum), 32'(e.s));
          chk("cout", 32'(bus.o_cout), 32'(e.c));
          chk("ovf", 32'(bus.o_ovf), 32'(e.o));
          if (exact) chk("latency", 32'(cyc - e.t), 32'(N));
          else chk("latency_min", 32'(cyc - e.t >= N), 32'(1));
        end
      end
      if (bus.i_valid && bus.o_ready) begin
        m = model(bus.iv_a, bus.iv_b, bus.i_cin, bus.i_sub);
        q.push_back('{s: m[W-1:0], c: m[W], o: m[W+1], t: cyc});
      end
      pstall = bus.o_valid && !bus.i_ready;
      pv = bus.o_valid;
      ps = bus.ov_sum;
      pc = bus.o_cout;
      po = bus.o_ovf;
    end
  end

  // present one beat from posedge+1 until accepted; leaves i_valid low afterwards
  task automatic beat(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci, input logic sub);
    int k = 0;
    bus.iv_a = a;
    bus.iv_b = b;
    bus.i_cin = ci;
    bus.i_sub = sub;
    bus.i_valid = 1'b1;
    @(negedge clk);
    while (!bus.o_ready && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (k == 200) chk("accept_timeout", 32'(1), 32'(0));
    @(posedge clk);
    #1;
    bus.i_valid = 1'b0;
  endtask

  task automatic rbeat();
    beat(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
  endtask

  task automatic send_chk(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci, input logic sub,
                          input logic [W-1:0] es, input logic ec, input logic eo);
    logic [W+1:0] m;
    int k = 0;
    m = model(a, b, ci, sub);
    chk("model_sum", 32'(m[W-1:0]), 32'(es));
    chk("model_cout", 32'(m[W]), 32'(ec));
    chk("model_ovf", 32'(m[W+1]), 32'(eo));
    beat(a, b, ci, sub);
    @(negedge clk);
    while (!bus.o_valid && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("dir_latency", 32'(k), 32'(N - 1));
    chk("dir_sum", 32'(bus.ov_sum), 32'(es));
    chk("dir_cout", 32'(bus.o_cout), 32'(ec));
    chk("dir_ovf", 32'(bus.o_ovf), 32'(eo));
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int k = 0;
    while (q.size() != 0 && k < 500) begin
      @(negedge clk);
      k++;
    end
    chk("drain_empty", 32'(q.size()), 32'(0));
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus.i_valid = 1'b1;
    bus.iv_a = 16'h1234;
    bus.iv_b = 16'h1111;
    bus.i_cin = 1'b0;
    bus.i_sub = 1'b0;
    bus.i_ready = 1'b1;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", 32'(bus.o_valid), 32'(0));
    chk("rst_sum", 32'(bus.ov_sum), 32'(0));
    chk("rst_cout", 32'(bus.o_cout), 32'(0));
    chk("rst_ovf", 32'(bus.o_ovf), 32'(0));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    bus.i_valid = 1'b0;
    @(negedge clk);
    chk("rst_ready", 32'(bus.o_ready), 32'(1));
    @(posedge clk);
    #1;
    exact = 1'b1;
    send_chk(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    send_chk(16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
    send_chk(16'h0000, 16'h0001, 1'b0, 1'b1, 16'hFFFF, 1'b0, 1'b0);
    send_chk(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
    send_chk(16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0);
    send_chk(16'h0005, 16'h0005, 1'b1, 1'b1, 16'hFFFF, 1'b0, 1'b0);
    for (int i = 0; i < 32; i++) rbeat();
    drain();
    exact = 1'b0;
    fork
      for (int i = 0; i < 12; i++) rbeat();
      begin
        bus.i_ready = 1'b0;
        repeat (6) @(negedge clk);
        chk("bp_ready_low", 32'(bus.o_ready), 32'(0));
        chk("bp_valid_high", 32'(bus.o_valid), 32'(1));
        repeat (4) @(posedge clk);
        #1;
        bus.i_ready = 1'b1;
      end
    join
    drain();
    done = 1'b0;
    fork
      begin
        for (int i = 0; i < 60; i++) begin
          rbeat();
          if ($urandom_range(0, 3) == 0) begin
            @(posedge clk);
            #1;
          end
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          bus.i_ready = 1'b1 & 1'($urandom_range(0, 1));
          @(posedge clk);
          #1;
        end
      end
    join
    bus.i_ready = 1'b1;
    drain();
    exact = 1'b1;
    for (int i = 0; i < 3; i++) rbeat();
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("midrst_valid", 32'(bus.o_valid), 32'(0));
    chk("midrst_sum", 32'(bus.ov_sum), 32'(0));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    send_chk(16'hABCD, 16'h1111, 1'b0, 1'b0, 16'hBCDE, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
